// File: rtl/mag_cmp_pkg.sv
// Shared definitions for the sequential nibble-serial magnitude comparator.
package mag_cmp_pkg;

  localparam int NIB_W       = 4;
  localparam int NIBBLES_MIN = 1;
  localparam int NIBBLES_MAX = 8;

  // Wide enough for idx (0..NIBBLES_MAX-1) and for nexam (1..NIBBLES_MAX).
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/nib_cmp4.sv
// Combinational 4-bit magnitude compare with one-hot gt/eq/lt result.
module nib_cmp4
  import mag_cmp_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] y,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  assign gt = (x > y);
  assign eq = (x == y);
  assign lt = (x < y);

endmodule

// File: rtl/mag_cmp_seq.sv
// Sequential magnitude comparator: walks latched operands one nibble per
// cycle from the MSB nibble down, stopping at the first differing nibble or
// falling back to the cascade inputs when every nibble matches.
//
//   state | meaning
//   IDLE  | waiting for start; last result held on ogt/oeq/olt/nexam
//   SCAN  | comparing nibble idx of the latched operands, idx counts down
module mag_cmp_seq
  import mag_cmp_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NIB_W*NIBBLES-1:0] a,
  input  logic [NIB_W*NIBBLES-1:0] b,
  input  logic                     igt,
  input  logic                     ieq,
  input  logic                     ilt,
  output logic                     busy,
  output logic                     done,
  output logic                     ogt,
  output logic                     oeq,
  output logic                     olt,
  output logic [3:0]               nexam
);

  localparam int W = NIB_W * NIBBLES;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_q, b_q;
  logic             igt_q, ieq_q, ilt_q;

  logic [NIB_W-1:0] nib_a, nib_b;
  logic             n_gt, n_eq, n_lt;

  logic             accept, finish;
  logic             done_n, ogt_n, oeq_n, olt_n;
  logic [3:0]       nexam_n;

  // Select the nibble currently addressed by idx from both latched operands.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) begin
        nib_a = a_q[i*NIB_W +: NIB_W];
        nib_b = b_q[i*NIB_W +: NIB_W];
      end
    end
  end

  nib_cmp4 u_nib_cmp4 (
    .x  (nib_a),
    .y  (nib_b),
    .gt (n_gt),
    .eq (n_eq),
    .lt (n_lt)
  );

  assign accept = (state == IDLE) && start;
  assign finish = (state == SCAN) && (!n_eq || (idx == '0));

  // State register plus the operand/result registers it sequences.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      igt_q <= 1'b0;
      ieq_q <= 1'b0;
      ilt_q <= 1'b0;
      done  <= 1'b0;
      ogt   <= 1'b0;
      oeq   <= 1'b0;
      olt   <= 1'b0;
      nexam <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        igt_q <= igt;
        ieq_q <= ieq;
        ilt_q <= ilt;
        idx   <= IDX_W'(NIBBLES - 1);
      end else if ((state == SCAN) && !finish) begin
        idx <= idx - 1'b1;
      end
      done  <= done_n;
      ogt   <= ogt_n;
      oeq   <= oeq_n;
      olt   <= olt_n;
      nexam <= nexam_n;
    end
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start)  state_n = SCAN;
      SCAN:    if (finish) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered result; these only move on a terminating edge.
  always_comb begin
    done_n  = finish;
    ogt_n   = ogt;
    oeq_n   = oeq;
    olt_n   = olt;
    nexam_n = nexam;
    if (finish) begin
      nexam_n = 4'(NIBBLES) - idx;
      if (!n_eq) begin
        ogt_n = n_gt;
        oeq_n = 1'b0;
        olt_n = n_lt;
      end else begin
        ogt_n = ~ieq_q & ~ilt_q;
        oeq_n = ieq_q;
        olt_n = ~ieq_q & ~igt_q;
      end
    end
  end

  assign busy = (state == SCAN);

endmodule

// File: doc/mag_cmp_seq.md
MAG_CMP_SEQ -- requirements
Module: mag_cmp_seq

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, legal range 1..8: number of 4-bit nibbles per operand.
REQ-002 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request a comparison; accepted only when busy=0.
- a  input  4*NIBBLES  operand A, captured on the accepting edge.
- b  input  4*NIBBLES  operand B, captured on the accepting edge.
- igt, ieq, ilt  input  1 each  cascade inputs, captured on the accepting edge.
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse: result registers updated.
- ogt, oeq, olt  output  1 each  registered result, held until the next done.
- nexam  output  4  number of nibbles examined by the last comparison.

Function
REQ-003 The block SHALL have states IDLE and SCAN, plus a nibble index register idx.
REQ-004 The block SHALL sample start=1 in IDLE at edge E0, then latch a, b, igt, ieq and ilt, set idx=NIBBLES-1, enter SCAN and set busy=1.
REQ-005 The block SHALL ignore start while busy=1; a, b and the cascade inputs SHALL NOT affect an active scan.
REQ-006 In each SCAN cycle the block SHALL compare latched nibble idx, scanning MSB nibble first.
REQ-007 If the nibbles differ, the block SHALL terminate early at the next edge: ogt=(A nibble > B nibble), olt=(A nibble < B nibble), oeq=0.
REQ-008 If the nibbles are equal and idx>0, the block SHALL decrement idx and remain in SCAN.
REQ-009 If the nibbles are equal and idx=0, the block SHALL terminate with the cascade result: oeq=ieq, ogt=~ieq&~ilt, olt=~ieq&~igt.
REQ-010 The cascade result SHALL therefore give: ieq=1 -> eq only; igt=ilt=1 with ieq=0 -> all zero; all cascade inputs 0 -> ogt=olt=1.
REQ-011 At the terminating edge Ek, where k is the number of nibbles examined (1..NIBBLES), the block SHALL return to IDLE, clear busy, assert done for exactly the Ek..Ek+1 cycle and load nexam=k.
REQ-012 Latency from E0 to the done edge SHALL be k cycles: minimum 1, maximum NIBBLES.
REQ-013 The block SHALL accept start in the same cycle in which done=1, since busy=0 in that cycle; back-to-back throughput SHALL be one comparison per k+1 cycles.
REQ-014 ogt, oeq, olt and nexam SHALL change only at a terminating edge or on reset.

Reset
REQ-015 rst=1 at a rising edge SHALL force IDLE, idx=0, busy=0, done=0, ogt=oeq=olt=0 and nexam=0, overriding start.
REQ-016 rst asserted mid-scan SHALL abort the scan with no done pulse; the next start after rst deasserts SHALL be accepted normally.

Structure
REQ-017 Package mag_cmp_pkg SHALL hold the state encoding (IDLE, SCAN), the constant NIB_W=4 and the NIBBLES legal-range bounds.
REQ-018 Sub-module nib_cmp4 SHALL be purely combinational: two 4-bit inputs in, one-hot gt/eq/lt out; mag_cmp_seq SHALL instantiate exactly one nib_cmp4 and mux the selected nibble into it.
REQ-019 All outputs SHALL be driven from registers, with no combinational path from inputs to outputs.

Verification (NIBBLES=4)
REQ-020 The bench SHALL cover: a=16'h1234, b=16'h1234, ieq=1 -> done 4 cycles after E0; oeq=1, ogt=olt=0, nexam=4.
REQ-021 The bench SHALL cover: a=16'h8000, b=16'h7FFF -> done 1 cycle after E0; ogt=1, oeq=olt=0, nexam=1.
REQ-022 The bench SHALL cover: a=16'h12A4, b=16'h12B4 -> done 3 cycles after E0; olt=1, nexam=3.
REQ-023 The bench SHALL cover equal operands 16'hFFFF with cascade igt=ilt=ieq=0 -> ogt=olt=1, oeq=0; then igt=ilt=1, ieq=0 -> all 0.
REQ-024 The bench SHALL cover: start plus changed a/b during busy -> request ignored, result matches the original operands; start on the done cycle -> new scan begins the next cycle.
REQ-025 The bench SHALL cover: rst at cycle 2 of a 4-nibble scan -> busy=0, done=0, all outputs 0 the next cycle; no done pulse follows.
